instr_fetch: RTL and testbench



---
 rtl/fetch_pkg.sv | 17 +
 rtl/fetch_timer.sv | 32 +++
 rtl/instr_fetch.sv | 108 ++++++++++
 tb/tb_instr_fetch.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch responder.
package fetch_pkg;

  localparam int INSTR_W = 32;

  // addi x0, x0, 0 : what the core sees on instr when no valid fetch exists
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    WAIT  = 3'd2,
    DONE  = 3'd3,
    FAULT = 3'd4
  } fetch_state_t;

endpackage

// File: rtl/fetch_timer.sv
// Time-out counter for the WAIT phase of a fetch.
// The count includes the current enabled cycle, so with TIMEOUT=N the
// expired flag rises in the N-th enabled cycle after a clear.
module fetch_timer #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = $clog2(TIMEOUT + 1)
) (
  input  logic clk,
  input  logic RST,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(TIMEOUT);

  logic [CNT_W-1:0] r_count;

  // Count enabled cycles, saturating at TIMEOUT so it never wraps.
  always_ff @(posedge clk) begin
    if (RST || clr) begin
      r_count <= '0;
    end else if (en && (r_count != MAX_CNT)) begin
      r_count <= r_count + 1'b1;
    end
  end

  // r_count holds the cycles already waited; this cycle makes it TIMEOUT.
  assign expired = en && (r_count == LAST_IDX);

endmodule

// File: rtl/instr_fetch.sv
// Instruction-fetch responder: one bus read per PC address, one-cycle
// iready pulse on completion, sticky fault on misalignment or time-out.
//
// Handshakes:
//   PC side  : PCaddr is sampled only in IDLE when stall=0; iready is a
//              single-cycle pulse and instr holds its value until the next.
//   Bus side : mem_req/mem_addr stay stable until mem_gnt=1 (transfer of the
//              request); mem_ack is honoured only in WAIT, any other ack is
//              dropped.
// State is visible internally as r_state (fetch_state_t) for checkers.
module instr_fetch
  import fetch_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = $clog2(TIMEOUT + 1)
) (
  input  logic               clk,
  input  logic               RST,
  input  logic [INSTR_W-1:0] PCaddr,
  input  logic               stall,
  output logic               iready,
  output logic [INSTR_W-1:0] instr,
  output logic               fetch_err,
  output logic               mem_req,
  output logic [INSTR_W-1:0] mem_addr,
  input  logic               mem_gnt,
  input  logic               mem_ack,
  input  logic [INSTR_W-1:0] mem_rdata
);

  fetch_state_t       r_state;
  fetch_state_t       w_next_state;
  logic [INSTR_W-1:0] r_mem_addr;
  logic [INSTR_W-1:0] r_instr;
  logic               w_misaligned;
  logic               w_start;
  logic               w_timer_clr;
  logic               w_timer_en;
  logic               w_expired;
  logic               w_capture;
  logic               w_enter_fault;

  assign w_misaligned  = (PCaddr[1:0] != 2'b00);
  assign w_start       = (r_state == IDLE) && !stall && !w_misaligned;
  assign w_timer_clr   = (r_state == REQ) && mem_gnt;
  assign w_timer_en    = (r_state == WAIT);
  assign w_capture     = (r_state == WAIT) && mem_ack;
  assign w_enter_fault = (w_next_state == FAULT) && (r_state != FAULT);

  fetch_timer #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) u_timer (
    .clk     (clk),
    .RST     (RST),
    .clr     (w_timer_clr),
    .en      (w_timer_en),
    .expired (w_expired)
  );

  // Next-state decode; an ack in the expiry cycle still completes the fetch.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (!stall) begin
          w_next_state = w_misaligned ? FAULT : REQ;
        end
      end
      REQ: begin
        if (mem_gnt) w_next_state = WAIT;
      end
      WAIT: begin
        if (mem_ack)        w_next_state = DONE;
        else if (w_expired) w_next_state = FAULT;
      end
      DONE:    w_next_state = IDLE;
      FAULT:   w_next_state = FAULT;
      default: w_next_state = IDLE;
    endcase
  end

  // State register; FAULT is left only through reset.
  always_ff @(posedge clk) begin
    if (RST) r_state <= IDLE;
    else     r_state <= w_next_state;
  end

  // Bus address latch, loaded only when a well-formed fetch starts.
  always_ff @(posedge clk) begin
    if (RST)          r_mem_addr <= '0;
    else if (w_start) r_mem_addr <= PCaddr;
  end

  // Instruction register: read data on ack, NOP when a fault begins.
  always_ff @(posedge clk) begin
    if (RST)                r_instr <= NOP_INSTR;
    else if (w_capture)     r_instr <= mem_rdata;
    else if (w_enter_fault) r_instr <= NOP_INSTR;
  end

  assign iready    = (r_state == DONE);
  assign mem_req   = (r_state == REQ);
  assign fetch_err = (r_state == FAULT);
  assign mem_addr  = r_mem_addr;
  assign instr     = r_instr;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with an instruction scoreboard.
module tb_instr_fetch;
  import fetch_pkg::*;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        RST;
  logic [31:0] PCaddr;
  logic        stall;
  logic        iready;
  logic [31:0] instr;
  logic        fetch_err;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_gnt;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int t, u, w, a, b, d, e;

  logic [31:0] exp_q[$];
  int          exp_cyc_q[$];

  instr_fetch #(.TIMEOUT(TO)) dut (
    .clk       (clk),
    .RST       (RST),
    .PCaddr    (PCaddr),
    .stall     (stall),
    .iready    (iready),
    .instr     (instr),
    .fetch_err (fetch_err),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_gnt   (mem_gnt),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // advance into the next cycle; inputs driven after this apply to it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic expect_instr(input logic [31:0] v, input int at);
    exp_q.push_back(v);
    exp_cyc_q.push_back(at);
  endtask

  // scoreboard monitor: every iready pulse must match the next expectation
  always @(negedge clk) begin
    if (iready === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_iready: got pulse at cycle %0d expected none", cyc);
      end else begin
        logic [31:0] ev;
        int          ec;
        ev = exp_q.pop_front();
        ec = exp_cyc_q.pop_front();
        chk("instr", instr, ev);
        chk("iready_cycle", cyc, ec);
      end
    end
  end

  initial begin
    RST = 1'b1; stall = 1'b0; PCaddr = '0;
    mem_gnt = 1'b0; mem_ack = 1'b0; mem_rdata = '0;
    step(); step(); mid();
    chk("rst_iready", {31'b0, iready}, 32'd0);
    chk("rst_instr", instr, NOP_INSTR);
    chk("rst_fetch_err", {31'b0, fetch_err}, 32'd0);
    chk("rst_mem_req", {31'b0, mem_req}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);

    // minimum-latency fetch, grant and ack tied high
    step(); RST = 1'b0; mem_gnt = 1'b1; mem_ack = 1'b1; mem_rdata = 32'h0050_0093;
    t = cyc; expect_instr(32'h0050_0093, t + 3);
    step(); mid();
    chk("s1_mem_req", {31'b0, mem_req}, 32'd1);
    chk("s1_mem_addr", mem_addr, 32'd0);
    step(); stall = 1'b1;
    step();
    step(); mem_gnt = 1'b0; mem_ack = 1'b0; mid();
    chk("s1_idle_req", {31'b0, mem_req}, 32'd0);

    // grant delayed 3 cycles, ack delayed 2, early ack in REQ ignored
    step(); u = cyc; stall = 1'b0; PCaddr = 32'h0000_0100; mem_rdata = 32'hDEAD_BEEF;
    expect_instr(32'h00A0_0113, u + 8);
    step(); PCaddr = 32'h0000_0200; mid();
    chk("s2_req1", {31'b0, mem_req}, 32'd1);
    chk("s2_addr1", mem_addr, 32'h0000_0100);
    step(); mem_ack = 1'b1; mid();
    chk("s2_addr2", mem_addr, 32'h0000_0100);
    step(); mem_ack = 1'b0; mid();
    chk("s2_addr3", mem_addr, 32'h0000_0100);
    step(); mem_gnt = 1'b1; mid();
    chk("s2_req4", {31'b0, mem_req}, 32'd1);
    chk("s2_addr4", mem_addr, 32'h0000_0100);
    step(); mem_gnt = 1'b0; mem_rdata = 32'h00A0_0113; mid();
    chk("s2_wait_req", {31'b0, mem_req}, 32'd0);
    step();
    step(); mem_ack = 1'b1; stall = 1'b1;
    step(); mem_ack = 1'b0; PCaddr = 32'h0000_0104;

    // stall held 5 cycles in IDLE
    for (int i = 0; i < 5; i++) begin
      step(); mid();
      chk("stall_no_req", {31'b0, mem_req}, 32'd0);
    end
    step(); w = cyc; stall = 1'b0; mem_gnt = 1'b1; mem_ack = 1'b1; mem_rdata = 32'h00C0_0193;
    expect_instr(32'h00C0_0193, w + 3);
    step(); mid();
    chk("s3_req", {31'b0, mem_req}, 32'd1);
    chk("s3_addr", mem_addr, 32'h0000_0104);
    step(); stall = 1'b1;
    step();
    step(); mem_gnt = 1'b0; mem_ack = 1'b0;

    // ack on the last WAIT cycle before time-out completes normally
    step(); a = cyc; stall = 1'b0; PCaddr = 32'h0000_0108; mem_gnt = 1'b1;
    mem_rdata = 32'h0010_0213; expect_instr(32'h0010_0213, a + 6);
    step();
    step(); mem_gnt = 1'b0;
    step();
    step();
    step(); mem_ack = 1'b1; stall = 1'b1;
    step(); mem_ack = 1'b0;
    step(); mid();
    chk("to_ack_no_err", {31'b0, fetch_err}, 32'd0);

    // misaligned address faults without a bus request
    step(); stall = 1'b0; PCaddr = 32'h0000_0006; mem_gnt = 1'b1; mem_ack = 1'b1;
    mem_rdata = 32'h1111_1111;
    for (int i = 0; i < 4; i++) begin
      step(); PCaddr = 32'h0000_010C; mid();
      chk("mis_err", {31'b0, fetch_err}, 32'd1);
      chk("mis_instr", instr, NOP_INSTR);
      chk("mis_req", {31'b0, mem_req}, 32'd0);
    end

    step(); RST = 1'b1; mem_gnt = 1'b0; mem_ack = 1'b0; stall = 1'b1;
    step(); RST = 1'b0; mid();
    chk("rst2_err", {31'b0, fetch_err}, 32'd0);
    chk("rst2_instr", instr, NOP_INSTR);

    // one good fetch, then a fetch whose ack never arrives
    step(); b = cyc; stall = 1'b0; PCaddr = 32'h0000_010C; mem_gnt = 1'b1; mem_ack = 1'b1;
    mem_rdata = 32'h0020_0293; expect_instr(32'h0020_0293, b + 3);
    step();
    step();
    step(); mem_ack = 1'b0; PCaddr = 32'h0000_0110;
    step();
    step();
    step(); mem_gnt = 1'b0; mid();
    chk("to_wait_req", {31'b0, mem_req}, 32'd0);
    step();
    step();
    step(); mid();
    chk("to_w4_no_err", {31'b0, fetch_err}, 32'd0);
    step(); mid();
    chk("to_err", {31'b0, fetch_err}, 32'd1);
    chk("to_instr", instr, NOP_INSTR);
    chk("to_req", {31'b0, mem_req}, 32'd0);
    step(); mem_ack = 1'b1;
    step(); mem_ack = 1'b0; mid();
    chk("to_sticky", {31'b0, fetch_err}, 32'd1);

    // reset in WAIT together with ack, then a late ack
    step(); RST = 1'b1; stall = 1'b1;
    step(); RST = 1'b0;
    step(); d = cyc; stall = 1'b0; PCaddr = 32'h0000_0114; mem_gnt = 1'b1; mem_ack = 1'b0;
    step();
    step(); mem_gnt = 1'b0; RST = 1'b1; mem_ack = 1'b1; mem_rdata = 32'h0BAD_BAD3; stall = 1'b1;
    step(); RST = 1'b0; mid();
    chk("rst_ack_instr", instr, NOP_INSTR);
    chk("rst_ack_req", {31'b0, mem_req}, 32'd0);
    chk("rst_ack_err", {31'b0, fetch_err}, 32'd0);
    step(); mem_ack = 1'b0; mid();
    chk("late_ack_instr", instr, NOP_INSTR);

    // normal fetch after the reset
    step(); e = cyc; stall = 1'b0; PCaddr = 32'h0000_0118; mem_gnt = 1'b1; mem_ack = 1'b1;
    mem_rdata = 32'h0030_0313; expect_instr(32'h0030_0313, e + 3);
    step(); mid();
    chk("post_req", {31'b0, mem_req}, 32'd1);
    chk("post_addr", mem_addr, 32'h0000_0118);
    step(); stall = 1'b1;
    step();
    step(); mem_gnt = 1'b0; mem_ack = 1'b0;
    step();
    step(); mid();
    chk("exp_q_drained", exp_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
